// File: rtl/rr_arbiter8.sv
// rr_arbiter8: round-robin arbiter sharing one resource among eight requesters.
// The winner is reported both as a one-hot grant and as a 3-bit binary index.
// A grant is held until done, until the owner drops its request, or until
// MAX_HOLD cycles have elapsed. After a forced release, timeout pulses for one cycle.
//
// Handshake: req[n] is a level request from requester n. While gnt[n] is high,
// requester n owns the resource. The owner ends its tenure by pulsing done or by
// dropping req[n]. done is only meaningful while busy is high.
module rr_arbiter8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

  state_e     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] hcnt_q, hcnt_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] gnt_id_q, gnt_id_d;
  logic       busy_q, busy_d;
  logic       timeout_q, timeout_d;

  logic       win_found;
  logic [2:0] win_id;

  // Rotating-priority search: the first set request at ptr, ptr+1, ..., ptr+7 (mod 8).
  always_comb begin
    logic [2:0] idx;
    win_found = 1'b0;
    win_id    = 3'd0;
    idx       = 3'd0;
    for (int i = 0; i < 8; i++) begin
      idx = ptr_q + 3'(i);
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

  // Next-state and registered-output logic for the IDLE/GRANT controller.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hcnt_d    = hcnt_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // done is deliberately not looked at here.
        if (win_found) begin
          state_d  = ST_GRANT;
          gnt_d    = 8'd1 << win_id;
          gnt_id_d = win_id;
          busy_d   = 1'b1;
          hcnt_d   = 8'd1;
        end
      end
      ST_GRANT: begin
        if (done || !req[gnt_id_q] || (hcnt_q == MAX_HOLD_C)) begin
          // A normal release (done or withdrawn request) masks the hold limit.
          timeout_d = !done && req[gnt_id_q];
          state_d   = ST_IDLE;
          gnt_d     = 8'd0;
          gnt_id_d  = 3'd0;
          busy_d    = 1'b0;
          hcnt_d    = 8'd0;
          // The just-served requester drops to the lowest priority.
          ptr_d     = gnt_id_q + 3'd1;
        end else begin
          // Cannot overflow: a release always happens at MAX_HOLD <= 255.
          hcnt_d = hcnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= 3'd0;
      hcnt_q    <= 8'd0;
      gnt_q     <= 8'd0;
      gnt_id_q  <= 3'd0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hcnt_q    <= hcnt_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: directed scoreboard bench for rr_arbiter8 with MAX_HOLD=4.
// Each step drives req/done for one cycle and queues the outputs expected
// after the next rising edge as {gnt, gnt_id, busy, timeout}.
module tb_rr_arbiter8;

  localparam int W = 13;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       busy;
  logic       timeout;

  logic [W-1:0] exp_q[$];
  int n_checks;
  int n_fails;

  rr_arbiter8 #(.MAX_HOLD(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .timeout (timeout)
  );

  // Clock generation.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected output word for a granted requester.
  function automatic logic [W-1:0] granted(input int id);
    logic [7:0] oh;
    oh = 8'd1 << id;
    return {oh, 3'(id), 1'b1, 1'b0};
  endfunction

  // Expected output word for an idle cycle, with or without a timeout pulse.
  function automatic logic [W-1:0] idle(input logic to);
    return {8'd0, 3'd0, 1'b0, to};
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got gnt=%b id=%0d busy=%b to=%b, want gnt=%b id=%0d busy=%b to=%b",
               tag, obs[12:5], obs[4:2], obs[1], obs[0], exp[12:5], exp[4:2], exp[1], exp[0]);
    end
  endtask

  // Drive one cycle of stimulus, push the expected result, compare after the edge.
  task automatic cyc(input string tag, input logic [7:0] r, input logic d, input logic [W-1:0] e);
    logic [W-1:0] exp_v;
    req  = r;
    done = d;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    check(tag, {gnt, gnt_id, busy, timeout}, exp_v);
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst  = 1'b1;
    req  = 8'd0;
    done = 1'b0;

    // Reset, then a single request.
    cyc("reset0", 8'h00, 1'b0, idle(1'b0));
    cyc("reset1", 8'h00, 1'b0, idle(1'b0));
    rst = 1'b0;
    cyc("idle_noreq", 8'h00, 1'b1, idle(1'b0));
    cyc("single_gnt", 8'h04, 1'b0, granted(2));
    cyc("single_rel", 8'h04, 1'b1, idle(1'b0));
    // ptr is now 3: with requests at 2 and 3, requester 3 wins.
    cyc("ptr_after2", 8'h0C, 1'b0, granted(3));
    cyc("ptr_after2_rel", 8'h0C, 1'b1, idle(1'b0));

    // Fairness from a fresh pointer: 0..7 then 0 again.
    rst = 1'b1;
    cyc("reset_fair", 8'hFF, 1'b0, idle(1'b0));
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      cyc($sformatf("rr_gnt%0d", i), 8'hFF, 1'b0, granted(i % 8));
      cyc($sformatf("rr_rel%0d", i), 8'hFF, 1'b1, idle(1'b0));
    end

    // Pointer wrap (ptr is 1 here).
    cyc("wrap_g7", 8'h80, 1'b0, granted(7));
    cyc("wrap_r7", 8'h80, 1'b1, idle(1'b0));
    cyc("wrap_g0", 8'h81, 1'b0, granted(0));
    cyc("wrap_r0", 8'h81, 1'b1, idle(1'b0));
    cyc("wrap_g7b", 8'h81, 1'b0, granted(7));
    cyc("wrap_r7b", 8'h81, 1'b1, idle(1'b0));

    // Hold limit: exactly four grant cycles, then timeout, then regrant.
    for (int i = 0; i < 4; i++) cyc($sformatf("hold%0d", i), 8'h10, 1'b0, granted(4));
    cyc("timeout", 8'h10, 1'b0, idle(1'b1));
    cyc("regrant4", 8'h10, 1'b0, granted(4));
    cyc("regrant4_rel", 8'h10, 1'b1, idle(1'b0));

    // Withdrawal of request 5: release without timeout.
    cyc("wd_g5", 8'h20, 1'b0, granted(5));
    cyc("wd_rel", 8'h00, 1'b0, idle(1'b0));

    // done arrives in the same cycle as the hold limit: no timeout.
    for (int i = 0; i < 4; i++) cyc($sformatf("coll%0d", i), 8'h40, 1'b0, granted(6));
    cyc("coll_rel", 8'h40, 1'b1, idle(1'b0));

    // done together with a dropped request: a single normal release.
    cyc("dd_g7", 8'h80, 1'b0, granted(7));
    cyc("dd_rel", 8'h00, 1'b1, idle(1'b0));
    cyc("dd_idle", 8'h00, 1'b0, idle(1'b0));

    // Reset during a grant to requester 6 (ptr is 0 here).
    cyc("mr_g6", 8'h40, 1'b0, granted(6));
    cyc("mr_hold", 8'h40, 1'b0, granted(6));
    cyc("mr_hold2", 8'h40, 1'b0, granted(6));
    cyc("mr_hold3", 8'h40, 1'b0, granted(6));
    rst = 1'b1;
    cyc("mr_reset", 8'hFF, 1'b0, idle(1'b0));
    rst = 1'b0;
    cyc("mr_g0", 8'hFF, 1'b0, granted(0));
    cyc("mr_rel", 8'hFF, 1'b1, idle(1'b0));
    cyc("mr_g1", 8'hFF, 1'b0, granted(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Round-robin arbiter that shares one resource among eight requesters and reports the winner both one-hot and as a 3-bit binary index, matching the 8-to-3 encoding used elsewhere in the design. It sits in front of any single-ported datapath that eight sources must take turns on. It holds a grant until the owner signals completion, withdraws its request, or exceeds a hold limit. Fairness comes from a rotating priority pointer.

## Interface

- MAX_HOLD, 16: maximum consecutive cycles one grant may be held. Legal range 1..255.
- clk  input  1  rising-edge clock; all state updates on this edge.
- rst  input  1  synchronous, active-high reset.
- req  input  8  request vector; bit n is requester n.
- done  input  1  current owner releases the resource; sampled only in GRANT.
- gnt  output  8  one-hot grant; all zeros when idle.
- gnt_id  output  3  binary index of the granted requester; 0 when idle.
- busy  output  1  high while a grant is outstanding (equals |gnt).
- timeout  output  1  one-cycle pulse when a grant is forcibly revoked by MAX_HOLD.

## Operation

- All outputs are registered. Internal state is `state` (IDLE/GRANT), a 3-bit pointer `ptr`, and an 8-bit hold counter `hcnt`.
- Reset values: state=IDLE, ptr=0, hcnt=0, gnt=0, gnt_id=0, busy=0, timeout=0.
- IDLE behaviour:
  - If req==0, remain in IDLE.
  - Otherwise select the first set bit of req searching ptr, ptr+1, …, ptr+7, all modulo 8.
  - Load gnt with the one-hot winner and gnt_id with its index, set busy=1, set hcnt=1, and go to GRANT.
- GRANT release conditions, evaluated each cycle in priority order:
  1. done=1 → normal release.
  2. req[gnt_id]=0 → normal release. This covers a requester that withdraws its request.
  3. hcnt==MAX_HOLD → forced release; timeout=1 on the next cycle.
  4. Otherwise stay in GRANT and increment hcnt. hcnt is 8 bits and never wraps, because a release occurs at MAX_HOLD.
- On any release:
  - Next cycle: gnt=0, gnt_id=0, busy=0, state=IDLE.
  - ptr ← gnt_id+1, modulo 8; index 7 wraps to 0.
  - hcnt ← 0.
- timeout is high only on the first IDLE cycle after a forced release; otherwise it is 0.
- Changes on req during GRANT never move the grant to a different requester.
- done is ignored in IDLE.
- A requester with no request set is never granted. The just-served requester has the lowest priority on the next arbitration.

## Timing

- Grant latency: req seen in IDLE at edge t → gnt/gnt_id/busy valid after edge t (cycle t+1).
- Release latency: a release condition seen at edge t → gnt=0 in cycle t+1.
  - Earliest next grant is cycle t+2, so there is one mandatory idle cycle between owners.
- Hold limit: a requester holding req with no done keeps gnt for exactly MAX_HOLD cycles. timeout pulses in the cycle after the last grant cycle.
- Simultaneous events:
  - done=1 and hcnt==MAX_HOLD in the same cycle → normal release, timeout stays 0.
  - done=1 and req[gnt_id]=0 in the same cycle → single normal release.
- Reset mid-grant: rst=1 at edge t → all outputs at reset values in cycle t+1, with no timeout pulse. ptr returns to 0.
- MAX_HOLD=1: every grant lasts exactly one cycle. timeout pulses after every grant that is not released by done or by dropping req.

## Test plan

- Reset then single request: rst for 2 cycles, then req=8'b0000_0100 → gnt=8'b0000_0100 and gnt_id=3'd2 one cycle later. Then done=1 for one cycle → gnt=0 next cycle and ptr=3.
- Round-robin fairness: hold req=8'hFF and pulse done one cycle after each grant → gnt_id sequence 0,1,2,3,4,5,6,7,0, with one idle cycle between grants.
- Pointer wrap:
  - Release a grant to requester 7 (ptr becomes 0), then req=8'b1000_0001 → gnt_id=0.
  - Then release requester 0 with req still 8'b1000_0001 → gnt_id=7.
- Timeout (MAX_HOLD=4): req=8'b0001_0000 held, done=0 → gnt held exactly 4 cycles, then gnt=0 with timeout=1 for one cycle. A regrant to requester 4 follows one cycle later.
- Request withdrawal and collision: grant requester 5, then drop req[5] while done=0 → release next cycle, with no timeout.
  - In a separate run, assert done in the same cycle that hcnt reaches MAX_HOLD → release with timeout=0.
- Reset mid-grant: while gnt=8'b0100_0000, assert rst → next cycle gnt=0, gnt_id=0, busy=0, timeout=0. With req=8'hFF the next grant is to requester 0.
